// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: drives pcWrEn/newPc for branch redirects,
// hazard stalls, multi-cycle SIMD stalls and halt, plus the IF/ID bubble.
//
// state | meaning
// RUN   | normal fetch, PC advances on its own
// REDIR | one cycle of pcWrEn to load the branch target, flush wrong-path fetch
// HOLD  | PC frozen at holdPc while a hazard or SIMD op is outstanding
// DRAIN | enable dropped; fetch still selects newPc, delivering holdPc once
// HALT  | PC frozen at holdPc until resume or a branch
module fetch_ctrl #(
  parameter int instSize = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branchReq,
  input  logic [instSize+7:0]   branchTarget,
  input  logic                  stallReq,
  input  logic [instSize+7:0]   holdPc,
  input  logic                  vecStart,
  input  logic [3:0]            vecLen,
  input  logic                  haltReq,
  input  logic                  resume,
  output logic                  pcWrEn,
  output logic [instSize+7:0]   newPc,
  output logic                  ifIdFlush,
  output logic                  halted,
  output logic [2:0]            state
);

  localparam int PcW = instSize + 8;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_REDIR = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       vec_cnt_q, vec_cnt_d;
  logic [PcW-1:0]   new_pc_q, new_pc_d;
  logic             pc_wr_en_q, pc_wr_en_d;
  logic             if_id_flush_q, if_id_flush_d;
  logic             halted_q, halted_d;

  logic             vec_go;
  logic [3:0]       cnt_dec;
  logic [3:0]       cnt_base;
  logic [3:0]       cnt_load;
  logic [3:0]       cnt_hold;

  always_comb begin
    vec_go   = vecStart && (vecLen != 4'd0);
    cnt_dec  = (vec_cnt_q == 4'd0) ? 4'd0 : vec_cnt_q - 4'd1;
    // In HOLD the counter already spends this cycle, so a reload competes
    // with what remains after it rather than with the stale value.
    cnt_base = (state_q == ST_HOLD) ? cnt_dec : vec_cnt_q;
    cnt_load = (vecLen > cnt_base) ? vecLen : cnt_base;
    cnt_hold = vec_go ? cnt_load : cnt_dec;

    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    new_pc_d  = new_pc_q;

    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (branchReq) begin
          state_d   = ST_REDIR;
          new_pc_d  = branchTarget;
          vec_cnt_d = 4'd0;
        end else if (haltReq) begin
          state_d   = ST_HALT;
          new_pc_d  = holdPc;
          vec_cnt_d = 4'd0;
        end else if (stallReq || vec_go) begin
          state_d   = ST_HOLD;
          new_pc_d  = holdPc;
          vec_cnt_d = vec_go ? cnt_load : vec_cnt_q;
        end else begin
          state_d   = ST_RUN;
        end
      end
      ST_REDIR: begin
        if (branchReq) begin
          state_d  = ST_REDIR;
          new_pc_d = branchTarget;
        end else begin
          state_d  = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (branchReq) begin
          state_d   = ST_REDIR;
          new_pc_d  = branchTarget;
          vec_cnt_d = 4'd0;
        end else if (haltReq) begin
          state_d   = ST_HALT;
          new_pc_d  = holdPc;
          vec_cnt_d = 4'd0;
        end else begin
          vec_cnt_d = cnt_hold;
          if (!stallReq && (cnt_hold == 4'd0)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_HALT: begin
        if (branchReq) begin
          state_d   = ST_REDIR;
          new_pc_d  = branchTarget;
          vec_cnt_d = 4'd0;
        end else if (resume) begin
          state_d   = ST_DRAIN;
        end
      end
      default: begin
        state_d   = ST_RUN;
        vec_cnt_d = 4'd0;
      end
    endcase

    pc_wr_en_d    = (state_d == ST_REDIR) || (state_d == ST_HOLD) || (state_d == ST_HALT);
    if_id_flush_d = pc_wr_en_d;
    halted_d      = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      vec_cnt_q     <= 4'd0;
      new_pc_q      <= '0;
      pc_wr_en_q    <= 1'b0;
      if_id_flush_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      vec_cnt_q     <= vec_cnt_d;
      new_pc_q      <= new_pc_d;
      pc_wr_en_q    <= pc_wr_en_d;
      if_id_flush_q <= if_id_flush_d;
      halted_q      <= halted_d;
    end
  end

  assign pcWrEn    = pc_wr_en_q;
  assign newPc     = new_pc_q;
  assign ifIdFlush = if_id_flush_q;
  assign halted    = halted_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a per-cycle vector table plus hand-written
// sequences for asynchronous reset in the middle of a stall.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        branchReq;
  logic [31:0] branchTarget;
  logic        stallReq;
  logic [31:0] holdPc;
  logic        vecStart;
  logic [3:0]  vecLen;
  logic        haltReq;
  logic        resume;
  logic        pcWrEn;
  logic [31:0] newPc;
  logic        ifIdFlush;
  logic        halted;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.instSize(24)) dut (
    .clk(clk), .rst(rst),
    .branchReq(branchReq), .branchTarget(branchTarget),
    .stallReq(stallReq), .holdPc(holdPc),
    .vecStart(vecStart), .vecLen(vecLen),
    .haltReq(haltReq), .resume(resume),
    .pcWrEn(pcWrEn), .newPc(newPc), .ifIdFlush(ifIdFlush),
    .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        st;
    logic [31:0] hp;
    logic        vs;
    logic [3:0]  vl;
    logic        hr;
    logic        rs;
    logic        e_we;
    logic [31:0] e_pc;
    logic        e_fl;
    logic        e_h;
    logic [2:0]  e_st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic br, input logic [31:0] tgt, input logic st,
                     input logic [31:0] hp, input logic vs, input logic [3:0] vl,
                     input logic hr, input logic rs, input logic e_we,
                     input logic [31:0] e_pc, input logic e_fl, input logic e_h,
                     input logic [2:0] e_st);
    vec_t v;
    v.br = br; v.tgt = tgt; v.st = st; v.hp = hp; v.vs = vs; v.vl = vl;
    v.hr = hr; v.rs = rs; v.e_we = e_we; v.e_pc = e_pc; v.e_fl = e_fl;
    v.e_h = e_h; v.e_st = e_st;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic e_we, input logic [31:0] e_pc,
                         input logic e_fl, input logic e_h, input logic [2:0] e_st);
    chk("pcWrEn", idx, {31'd0, pcWrEn}, {31'd0, e_we});
    chk("newPc", idx, newPc, e_pc);
    chk("ifIdFlush", idx, {31'd0, ifIdFlush}, {31'd0, e_fl});
    chk("halted", idx, {31'd0, halted}, {31'd0, e_h});
    chk("state", idx, {29'd0, state}, {29'd0, e_st});
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic st,
                       input logic [31:0] hp, input logic vs, input logic [3:0] vl,
                       input logic hr, input logic rs);
    branchReq = br; branchTarget = tgt; stallReq = st; holdPc = hp;
    vecStart = vs; vecLen = vl; haltReq = hr; resume = rs;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    // branch to 0x100: one redirect cycle, then newPc held
    add(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'h100, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0);
    // 3-cycle hazard stall at 0x40; later holdPc changes must not leak through
    add(0, 0, 1, 32'h40, 0, 0, 0, 0, 1, 32'h40, 1, 0, 2);
    add(0, 0, 1, 32'h44, 0, 0, 0, 0, 1, 32'h40, 1, 0, 2);
    add(0, 0, 1, 32'h48, 0, 0, 0, 0, 1, 32'h40, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0);
    // vecLen 5, then vecLen 2 on the second HOLD cycle: 5 HOLD cycles total
    add(0, 0, 0, 32'h80, 1, 5, 0, 0, 1, 32'h80, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 1, 0, 2);
    add(0, 0, 0, 32'h84, 1, 2, 0, 0, 1, 32'h80, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0, 0);
    // halt; stall and vecStart ignored; resume drains
    add(0, 0, 0, 32'h300, 0, 0, 1, 0, 1, 32'h300, 1, 1, 4);
    add(0, 0, 1, 32'h400, 0, 0, 0, 0, 1, 32'h300, 1, 1, 4);
    add(0, 0, 0, 32'h404, 1, 3, 0, 0, 1, 32'h300, 1, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 1, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    // branch out of HOLD with 3 cycles pending; a later 1-cycle stall proves the count was dropped
    add(0, 0, 0, 32'h60, 1, 4, 0, 0, 1, 32'h60, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h60, 1, 0, 2);
    add(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 0, 0, 0);
    add(0, 0, 1, 32'h64, 0, 0, 0, 0, 1, 32'h64, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h64, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h64, 0, 0, 0);
    // back-to-back branches
    add(1, 32'h500, 0, 0, 0, 0, 0, 0, 1, 32'h500, 1, 0, 1);
    add(1, 32'h504, 0, 0, 0, 0, 0, 0, 1, 32'h504, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h504, 0, 0, 0);
    // vecLen 0 is no stall; vecLen 1 is one HOLD cycle
    add(0, 0, 0, 32'h99, 1, 0, 0, 0, 0, 32'h504, 0, 0, 0);
    add(0, 0, 0, 32'h70, 1, 1, 0, 0, 1, 32'h70, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h70, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h70, 0, 0, 0);
    // branch clears halt
    add(0, 0, 0, 32'h90, 0, 0, 1, 0, 1, 32'h90, 1, 1, 4);
    add(1, 32'h600, 0, 0, 0, 0, 0, 0, 1, 32'h600, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h600, 0, 0, 0);
    // priority: branch beats halt and stall; halt beats stall
    add(1, 32'h700, 1, 32'h33, 0, 0, 1, 0, 1, 32'h700, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h700, 0, 0, 0);
    add(0, 0, 1, 32'h34, 0, 0, 1, 0, 1, 32'h34, 1, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h34, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h34, 0, 0, 0);
    // stall arriving during DRAIN re-enters HOLD with the new holdPc
    add(0, 0, 1, 32'hA0, 0, 0, 0, 0, 1, 32'hA0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA0, 0, 0, 3);
    add(0, 0, 1, 32'hB0, 0, 0, 0, 0, 1, 32'hB0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hB0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hB0, 0, 0, 0);

    #1;
    chk_all(-1, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].br, tbl[i].tgt, tbl[i].st, tbl[i].hp, tbl[i].vs, tbl[i].vl,
            tbl[i].hr, tbl[i].rs);
      @(posedge clk);
      #1;
      chk_all(i, tbl[i].e_we, tbl[i].e_pc, tbl[i].e_fl, tbl[i].e_h, tbl[i].e_st);
    end

    // asynchronous reset in the middle of a 7-cycle SIMD stall
    drive(0, 0, 0, 32'hC0, 1, 7, 0, 0);
    @(posedge clk);
    #1;
    chk_all(1000, 1, 32'hC0, 1, 0, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_all(1001, 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all(1002, 0, 32'h0, 0, 0, 0);
    // the discarded count must not stretch a fresh 1-cycle stall
    drive(0, 0, 1, 32'hD0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all(1003, 1, 32'hD0, 1, 0, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all(1004, 0, 32'hD0, 0, 0, 3);
    @(posedge clk);
    #1;
    chk_all(1005, 0, 32'hD0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction fetch stage. It drives the fetch stage's `pcWrEn` / `newPc` pair to redirect the PC on taken branches, freeze the PC for pipeline stalls, stall for multi-cycle SIMD operations, and halt the PC. It also drives the IF/ID bubble signal. The fetch stage registers `pcWrEn` one cycle before it selects `newPc`, and this controller's sequencing accounts for that delay.

## Interface
- `instSize`, 24, instruction width; PC width is `instSize+8`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `branchReq`  in  1  taken-branch/jump request, single-cycle pulse.
- `branchTarget`  in  instSize+8  redirect address, valid with `branchReq`.
- `stallReq`  in  1  hazard stall, level.
- `holdPc`  in  instSize+8  address to refetch after a stall or halt; sampled on entry to HOLD/HALT.
- `vecStart`  in  1  multi-cycle SIMD op issued, single-cycle pulse.
- `vecLen`  in  4  number of extra stall cycles for that op (0 = none).
- `haltReq`  in  1  halt request, pulse.
- `resume`  in  1  leave HALT, pulse.
- `pcWrEn`  out  1  to fetch `pcWrEn`.
- `newPc`  out  instSize+8  to fetch `newPc`.
- `ifIdFlush`  out  1  replace the IF/ID instruction with a bubble this cycle.
- `halted`  out  1  state == HALT.
- `state`  out  3  debug: RUN=0, REDIR=1, HOLD=2, DRAIN=3, HALT=4.

## Operation
- All outputs are registered. Reset values: state RUN, `pcWrEn` 0, `newPc` 0, `ifIdFlush` 0, `halted` 0, `vecCnt` 0.
- Priority at each edge: reset > `branchReq` > `haltReq` > `stallReq`/`vecStart` > normal sequencing.
- `vecCnt` (4-bit):
  - On `vecStart` with `vecLen`≠0, load `max(vecCnt, vecLen)`.
  - Decrement once per HOLD cycle, saturating at 0.
  - Cleared on entry to REDIR or HALT.
- RUN: `pcWrEn`=0, `ifIdFlush`=0, `newPc` holds its last value.
  - `branchReq` → REDIR, `newPc`=`branchTarget`.
  - `haltReq` → HALT.
  - `stallReq` or (`vecStart` and `vecLen`≠0) → HOLD, `newPc`=`holdPc`.
  - `resume` is ignored.
- REDIR: lasts exactly 1 cycle. `pcWrEn`=1, `ifIdFlush`=1 (wrong-path PC+4 instruction).
  - Next state is RUN, or REDIR again on a new `branchReq`.
- HOLD: `pcWrEn`=1, `ifIdFlush`=1, `newPc` frozen, so the fetch PC stays at `holdPc`.
  - When `stallReq`=0 and `vecCnt`=0 → DRAIN.
  - A new `vecStart` in HOLD reloads the counter per the rule above.
- DRAIN: lasts 1 cycle. `pcWrEn`=0, `ifIdFlush`=0, `newPc` held.
  - The fetch stage still selects `newPc` (delayed enable), so the `holdPc` instruction reaches decode exactly once.
  - Next state is RUN, unless `branchReq`/`haltReq`/`stallReq` arrives, which takes its transition instead.
- HALT: same outputs as HOLD, plus `halted`=1. `stallReq` and `vecStart` are ignored.
  - `resume` → DRAIN.
  - `branchReq` → REDIR, which clears the halt.
- `newPc` changes only on entry to REDIR, HOLD or HALT. It stays stable for at least the cycle after `pcWrEn` falls, as the fetch delay requires.

## Timing
- Branch accepted at edge E0:
  - `pcWrEn`=1 for E0–E1.
  - Fetch outputs mem[`branchTarget`] during E1–E2.
  - One bubble is inserted.
- Stall entered at E0, `stallReq` deasserted before edge Ek:
  - `ifIdFlush`=1 from E0 to Ek.
  - DRAIN runs Ek–Ek+1 and delivers mem[`holdPc`].
  - Fetch resumes at `holdPc`+4 from Ek+1.
- `vecLen`=N from RUN: exactly N HOLD cycles, then 1 DRAIN cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately. The pending counter and target are discarded.
- Address arithmetic is not performed here. All PC values pass through unmodified at `instSize+8` bits.

## Test plan
- Reset → all outputs 0 and `state`=0. Release reset, idle 5 cycles → `pcWrEn` stays 0.
- `branchReq`, `branchTarget`=0x100 → one cycle with `pcWrEn`=1, `newPc`=0x100, `ifIdFlush`=1. Next cycle `pcWrEn`=0 and `newPc` still 0x100.
- `stallReq` high for 3 cycles, `holdPc`=0x40 → HOLD with `ifIdFlush`=1 for 3 cycles, then DRAIN with `pcWrEn`=0, `ifIdFlush`=0, `newPc`=0x40, then RUN.
- `vecStart` with `vecLen`=5, then `vecStart` with `vecLen`=2 on the second HOLD cycle → 5 HOLD cycles total, then DRAIN.
- `haltReq` → `halted`=1. `stallReq` pulsed during HALT → no change. `resume` → DRAIN then RUN.
- `branchReq`=0x200 during HOLD with `vecCnt`=3 → REDIR then RUN. `vecCnt`=0 and `newPc`=0x200.
